hc148_sync: RTL

HC148_SYNC -- requirements
Module: hc148_sync

---
 rtl/hc148_pkg.sv | 23 ++
 rtl/sync_bus.sv | 25 ++
 rtl/hc148_sync.sv | 95 +++++++++
 3 files changed

// File: rtl/hc148_pkg.sv
// rtl/hc148_pkg.sv - shared types and constants for the synchronized 148-style priority encoder
package hc148_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_HOLD    = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [2:0] A_IDLE = 3'b111;
  localparam int SYNC_STAGES_DEFAULT = 2;

  // highest set bit wins; caller guarantees v != 0
  function automatic logic [2:0] top_index(input logic [7:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[i]) idx = 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sync_bus.sv
// rtl/sync_bus.sv - multi-flop synchronizer for a bus of independent active-low lines
module sync_bus #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '1;
    end else begin
      stage[0] <= d;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign q = stage[DEPTH-1];

endmodule

// File: rtl/hc148_sync.sv
// rtl/hc148_sync.sv - edge-captured, handshaked 8-line priority encoder with cascade enable
module hc148_sync
  import hc148_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       EI_N,
  input  logic [7:0] I_N,
  input  logic       ACK,
  output logic [2:0] A_N,
  output logic       GS_N,
  output logic       EO_N
);

  logic [7:0]             i_sync;
  logic [7:0]             smp;
  logic [7:0]             smp_d;
  logic [7:0]             fall;
  logic [7:0]             clr;
  logic [7:0]             pending;
  logic [7:0]             pending_nxt;
  logic [SYNC_STAGES-1:0] warm;
  state_t                 state;
  state_t                 state_nxt;

  sync_bus #(
    .WIDTH(8),
    .DEPTH(SYNC_STAGES)
  ) u_sync (
    .clk  (CLK),
    .rst_n(RST_N),
    .d    (I_N),
    .q    (i_sync)
  );

  // Samples read as low until the chain has flushed, so lines already low at
  // reset release never produce a high->low transition.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      warm  <= '0;
      smp   <= '0;
      smp_d <= '0;
    end else begin
      warm  <= {warm[SYNC_STAGES-2:0], 1'b1};
      smp   <= warm[SYNC_STAGES-1] ? i_sync : 8'h00;
      smp_d <= smp;
    end
  end

  assign fall        = smp_d & ~smp;
  assign clr         = (state == ST_HOLD && ACK) ? (8'd1 << ~A_N) : 8'h00;
  assign pending_nxt = (pending & ~clr) | fall;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (!EI_N && pending != 8'h00) state_nxt = ST_HOLD;
      ST_HOLD:    if (ACK) state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state   <= ST_IDLE;
      pending <= 8'h00;
      A_N     <= A_IDLE;
      GS_N    <= 1'b1;
      EO_N    <= 1'b1;
    end else begin
      state   <= state_nxt;
      pending <= pending_nxt;
      EO_N    <= !(!EI_N && state_nxt == ST_IDLE && pending_nxt == 8'h00);
      case (state)
        ST_IDLE: begin
          if (state_nxt == ST_HOLD) begin
            A_N  <= ~top_index(pending);
            GS_N <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (ACK) begin
            A_N  <= A_IDLE;
            GS_N <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
